// File: rtl/onehot_pkg.sv
// Shared mode encoding for the one-hot ring counter and its checker.
package onehot_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_ROR  = 2'b10;
  localparam logic [1:0] MODE_ROL  = 2'b11;

endpackage

// File: rtl/onehot_check.sv
// Combinational one-hot inspector: lowest-set-bit index, exactly-one-hot flag
// and all-zero flag for an N-bit vector.
module onehot_check #(
  parameter int N = 6,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o,
  output logic          zero_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

  assign zero_o  = ~|vec_i;
  assign valid_o = !zero_o && ((vec_i & (vec_i - N'(1))) == '0);

endmodule

// File: rtl/onehot_ring_counter.sv
// Parametrised one-hot ring counter with programmable stride, enable, binary
// index, wrap pulse and one-hot checking. Define ONEHOT_RECOVER_EN to reject
// non-one-hot loads (state forced to the reset position, ou_err pulses);
// otherwise loads are verbatim and ou_err flags any non-one-hot state.
// Inputs are sampled every enabled edge; there is no valid/ready handshake.
module onehot_ring_counter
  import onehot_pkg::*;
#(
  parameter int N         = 6,
  parameter int RESET_POS = 0,
  localparam int IW       = $clog2(N)
) (
  input  logic          in_clk,
  input  logic          rst,
  input  logic          in_en,
  input  logic [1:0]    in_sel,
  input  logic [N-1:0]  in_p,
  input  logic [IW-1:0] in_step,
  output logic [N-1:0]  ou_o,
  output logic [IW-1:0] ou_idx,
  output logic          ou_wrap,
  output logic          ou_err
);

  localparam logic [N-1:0] RESET_VEC = N'(1) << RESET_POS;
  localparam logic [IW:0]  N_W       = (IW + 1)'(N);

  logic [N-1:0]  o_q, o_d;
  logic          wrap_q, wrap_d;

  logic [IW-1:0] p_idx, o_idx;
  logic          p_valid, p_zero, o_valid, o_zero;

  onehot_check #(.N(N)) u_chk_p (
    .vec_i   (in_p),
    .idx_o   (p_idx),
    .valid_o (p_valid),
    .zero_o  (p_zero)
  );

  onehot_check #(.N(N)) u_chk_o (
    .vec_i   (o_q),
    .idx_o   (o_idx),
    .valid_o (o_valid),
    .zero_o  (o_zero)
  );

  // in_step < 2^IW < 2N, so a single conditional subtract reduces it mod N.
  logic [IW:0]   step_ext, s_ext, idx_sum;
  logic [IW-1:0] s;
  assign step_ext = {1'b0, in_step};
  assign s_ext    = (step_ext >= N_W) ? (step_ext - N_W) : step_ext;
  assign s        = s_ext[IW-1:0];
  assign idx_sum  = {1'b0, o_idx} + s_ext;

  logic          wrap_l, wrap_r;
  assign wrap_l = (s_ext != '0) && (idx_sum >= N_W);
  assign wrap_r = (s_ext != '0) && ({1'b0, o_idx} < s_ext);

  // Barrel rotate through a doubled copy of the ring.
  logic [2*N-1:0] dbl, dbl_l, dbl_r;
  logic [N-1:0]   rol, ror;
  assign dbl   = {o_q, o_q};
  assign dbl_l = dbl << s;
  assign dbl_r = dbl >> s;
  assign rol   = dbl_l[2*N-1:N];
  assign ror   = dbl_r[N-1:0];

`ifdef ONEHOT_RECOVER_EN
  logic err_q, err_d;
`endif

  always_comb begin
    o_d    = o_q;
    wrap_d = 1'b0;
`ifdef ONEHOT_RECOVER_EN
    err_d  = 1'b0;
`endif
    if (in_en) begin
      case (in_sel)
        MODE_LOAD: begin
`ifdef ONEHOT_RECOVER_EN
          if (p_valid) begin
            o_d = in_p;
          end else begin
            o_d   = RESET_VEC;
            err_d = 1'b1;
          end
`else
          o_d = in_p;
`endif
        end
        MODE_ROR: begin
          o_d    = ror;
          wrap_d = wrap_r;
        end
        MODE_ROL: begin
          o_d    = rol;
          wrap_d = wrap_l;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      o_q    <= RESET_VEC;
      wrap_q <= 1'b0;
    end else begin
      o_q    <= o_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef ONEHOT_RECOVER_EN
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
  assign ou_err = err_q;

  logic unused_chk;
  assign unused_chk = ^{p_idx, p_zero, o_valid, o_zero};
`else
  // Rotation preserves popcount, so this stays set until a valid load.
  assign ou_err = ~o_valid;

  logic unused_chk;
  assign unused_chk = ^{p_idx, p_zero, p_valid, o_zero};
`endif

  assign ou_o    = o_q;
  assign ou_idx  = o_idx;
  assign ou_wrap = wrap_q;

endmodule

// File: tb/tb_onehot_ring_counter.sv
// Self-checking bench for onehot_ring_counter (N=6, RESET_POS=0), with a
// position-level reference model; honours ONEHOT_RECOVER_EN like the DUT.
module tb_onehot_ring_counter;

  localparam int N         = 6;
  localparam int RESET_POS = 0;
  localparam int IW        = 3;
  localparam logic [N-1:0] RV = 6'b000001;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_ROR  = 2'b10;
  localparam logic [1:0] S_ROL  = 2'b11;

  logic          in_clk;
  logic          rst;
  logic          in_en;
  logic [1:0]    in_sel;
  logic [N-1:0]  in_p;
  logic [IW-1:0] in_step;
  logic [N-1:0]  ou_o;
  logic [IW-1:0] ou_idx;
  logic          ou_wrap;
  logic          ou_err;

  onehot_ring_counter #(.N(N), .RESET_POS(RESET_POS)) dut (
    .in_clk  (in_clk),
    .rst     (rst),
    .in_en   (in_en),
    .in_sel  (in_sel),
    .in_p    (in_p),
    .in_step (in_step),
    .ou_o    (ou_o),
    .ou_idx  (ou_idx),
    .ou_wrap (ou_wrap),
    .ou_err  (ou_err)
  );

  // ---------------- clock ----------------
  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int popcnt(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) if (v[i]) c++;
    return c;
  endfunction

  // Returns {err, wrap, state} after one edge.
  function automatic logic [N+1:0] model_next(input logic [N-1:0] cur, input logic cur_err,
                                              input logic en, input logic [1:0] sel,
                                              input logic [N-1:0] p, input logic [IW-1:0] step);
    int s, lo;
    logic [N-1:0] nx;
    logic w, e;
    s  = int'(step) % N;
    lo = lowest(cur);
    nx = cur;
    w  = 1'b0;
`ifdef ONEHOT_RECOVER_EN
    e = 1'b0;
`else
    e = cur_err;
`endif
    if (en) begin
      case (sel)
        S_LOAD: begin
`ifdef ONEHOT_RECOVER_EN
          if (popcnt(p) == 1) nx = p;
          else begin
            nx = RV;
            e  = 1'b1;
          end
`else
          nx = p;
          e  = (popcnt(p) != 1);
`endif
        end
        S_ROL: begin
          nx = '0;
          for (int i = 0; i < N; i++) if (cur[i]) nx[(i + s) % N] = 1'b1;
          w = (s != 0) && (lo + s >= N);
        end
        S_ROR: begin
          nx = '0;
          for (int i = 0; i < N; i++) if (cur[i]) nx[(i - s + N) % N] = 1'b1;
          w = (s != 0) && (lo < s);
        end
        default: ;
      endcase
    end
    return {e, w, nx};
  endfunction

  logic [N-1:0] m_o;
  logic         m_wrap;
  logic         m_err;

  always @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      m_o    <= RV;
      m_wrap <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      {m_err, m_wrap, m_o} <= model_next(m_o, m_err, in_en, in_sel, in_p, in_step);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge in_clk) begin
    if (chk_en) begin
      check("model_o",    32'(ou_o),    32'(m_o));
      check("model_idx",  32'(ou_idx),  32'(lowest(m_o)));
      check("model_wrap", 32'(ou_wrap), 32'(m_wrap));
      check("model_err",  32'(ou_err),  32'(m_err));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic en, input logic [1:0] sel,
                       input logic [N-1:0] p, input logic [IW-1:0] step);
    in_en   = en;
    in_sel  = sel;
    in_p    = p;
    in_step = step;
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    in_en = 1'b0; in_sel = S_HOLD; in_p = '0; in_step = '0;
    #12;
    check("rst_o",    32'(ou_o),    32'(6'b000001));
    check("rst_idx",  32'(ou_idx),  0);
    check("rst_wrap", 32'(ou_wrap), 0);
    check("rst_err",  32'(ou_err),  0);
    chk_en = 1'b1;
    @(negedge in_clk);
    rst = 1'b1;

    drive(1'b1, S_LOAD, 6'b001000, 3'd0);
    check("load_o",   32'(ou_o),   32'(6'b001000));
    check("load_idx", 32'(ou_idx), 3);
    for (int i = 0; i < 3; i++) drive(1'b0, S_ROL, 6'b0, 3'd1);
    check("en_hold_o",    32'(ou_o),    32'(6'b001000));
    check("en_hold_wrap", 32'(ou_wrap), 0);

    drive(1'b1, S_LOAD, 6'b100000, 3'd0);
    drive(1'b1, S_ROL, 6'b0, 3'd1);
    check("rol_wrap_o",    32'(ou_o),    32'(6'b000001));
    check("rol_wrap_idx",  32'(ou_idx),  0);
    check("rol_wrap_flag", 32'(ou_wrap), 1);
    drive(1'b1, S_ROL, 6'b0, 3'd1);
    check("rol_next_o",    32'(ou_o),    32'(6'b000010));
    check("rol_next_wrap", 32'(ou_wrap), 0);

    drive(1'b1, S_ROR, 6'b0, 3'd2);
    check("ror_wrap_o",    32'(ou_o),    32'(6'b100000));
    check("ror_wrap_idx",  32'(ou_idx),  5);
    check("ror_wrap_flag", 32'(ou_wrap), 1);

    drive(1'b1, S_LOAD, 6'b000001, 3'd0);
    drive(1'b1, S_ROL, 6'b0, 3'd7);
    check("step7_o",    32'(ou_o),    32'(6'b000010));
    check("step7_wrap", 32'(ou_wrap), 0);

    drive(1'b1, S_LOAD, 6'b000011, 3'd0);
`ifdef ONEHOT_RECOVER_EN
    check("bad_load_o",   32'(ou_o),   32'(6'b000001));
    check("bad_load_err", 32'(ou_err), 1);
    drive(1'b1, S_HOLD, 6'b0, 3'd0);
    check("err_pulse_end", 32'(ou_err), 0);
`else
    check("bad_load_o",   32'(ou_o),   32'(6'b000011));
    check("bad_load_idx", 32'(ou_idx), 0);
    check("bad_load_err", 32'(ou_err), 1);
    drive(1'b1, S_ROL, 6'b0, 3'd1);
    check("err_sticky", 32'(ou_err), 1);
    drive(1'b1, S_LOAD, 6'b000100, 3'd0);
    check("err_clear_o", 32'(ou_o),   32'(6'b000100));
    check("err_clear",   32'(ou_err), 0);
`endif

    // Randomised traffic, checked by the per-cycle compare.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] p;
      if ($urandom_range(0, 1) == 1) p = RV << $urandom_range(0, N - 1);
      else p = 6'($urandom_range(0, 63));
      drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), p, 3'($urandom_range(0, 7)));
    end

    // Asynchronous reset in the middle of a rotation.
    drive(1'b1, S_LOAD, 6'b000100, 3'd0);
    drive(1'b1, S_ROL, 6'b0, 3'd1);
    drive(1'b1, S_ROL, 6'b0, 3'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_o",    32'(ou_o),    32'(6'b000001));
    check("async_rst_idx",  32'(ou_idx),  0);
    check("async_rst_wrap", 32'(ou_wrap), 0);
    check("async_rst_err",  32'(ou_err),  0);
    @(negedge in_clk);
    rst = 1'b1;
    drive(1'b1, S_ROL, 6'b0, 3'd1);
    check("resume_o",   32'(ou_o),   32'(6'b000010));
    check("resume_idx", 32'(ou_idx), 1);

    @(negedge in_clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
